// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ARM execute-stage types: ALU ops, condition codes, flags, forwarding selects
package arm_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_ORR = 4'b0011,
      ALU_EOR = 4'b0100,
      ALU_RSB = 4'b0101,
      ALU_MOV = 4'b0110,
      ALU_MVN = 4'b0111,
      ALU_ADC = 4'b1000,
      ALU_SBC = 4'b1001
   } alu_op_t;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110
   } cond_t;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   localparam logic [1:0] FWD_REG     = 2'b00;
   localparam logic [1:0] FWD_RESULTW = 2'b01;
   localparam logic [1:0] FWD_ALUM    = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ARM ALU producing result and next NZCV
module alu
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   input  logic             cin,
   input  flags_t           flagsIn,
   output logic [WIDTH-1:0] result,
   output flags_t           flags_next
);

   logic [WIDTH-1:0] x, y, logicRes;
   logic [WIDTH:0]   sum;
   logic             ci, arith, valid;

   // Every arithmetic op is folded onto one adder: subtraction is x + ~y + 1,
   // so the carry out is directly the ARM not-borrow.
   always_comb begin
      x        = a;
      y        = b;
      ci       = 1'b0;
      arith    = 1'b0;
      valid    = 1'b1;
      logicRes = '0;
      case (op)
         ALU_ADD: arith = 1'b1;
         ALU_SUB: begin y = ~b; ci = 1'b1; arith = 1'b1; end
         ALU_RSB: begin x = b; y = ~a; ci = 1'b1; arith = 1'b1; end
         ALU_ADC: begin ci = cin; arith = 1'b1; end
         ALU_SBC: begin y = ~b; ci = cin; arith = 1'b1; end
         ALU_AND: logicRes = a & b;
         ALU_ORR: logicRes = a | b;
         ALU_EOR: logicRes = a ^ b;
         ALU_MOV: logicRes = b;
         ALU_MVN: logicRes = ~b;
         default: valid = 1'b0;
      endcase
   end

   assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};

   always_comb begin
      result     = '0;
      flags_next = flagsIn;
      if (valid) begin
         result       = arith ? sum[WIDTH-1:0] : logicRes;
         flags_next.n = result[WIDTH-1];
         flags_next.z = (result == '0);
         if (arith) begin
            flags_next.c = sum[WIDTH];
            flags_next.v = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
         end
      end
   end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - ARM execute stage: forwarding, ALU, NZCV register, condition check, E/M register
module execute_stage
   import arm_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] RD1E,
   input  logic [WIDTH-1:0] RD2E,
   input  logic [WIDTH-1:0] ExtImmE,
   input  logic [3:0]       WA3E,
   input  logic [3:0]       ALUControlE,
   input  logic [3:0]       CondE,
   input  logic [1:0]       FlagWriteE,
   input  logic             ALUSrcE,
   input  logic             RegWriteE,
   input  logic             MemWriteE,
   input  logic             MemToRegE,
   input  logic             PCSrcE,
   input  logic             BranchE,
   input  logic [1:0]       ForwardAE,
   input  logic [1:0]       ForwardBE,
   input  logic [WIDTH-1:0] ResultW,
   output logic             BranchTakenE,
   output logic [WIDTH-1:0] ALUResultE,
   output logic [WIDTH-1:0] ALUResultM,
   output logic [WIDTH-1:0] WriteDataM,
   output logic [3:0]       WA3M,
   output logic             RegWriteM,
   output logic             MemWriteM,
   output logic             MemToRegM,
   output logic             PCSrcM,
   output logic [3:0]       FlagsQ
);

   logic [WIDTH-1:0] srcA, srcB, writeDataE;
   flags_t           flagsR, aluFlags;
   logic             condEx;

   always_comb begin
      case (ForwardAE)
         FWD_RESULTW: srcA = ResultW;
         FWD_ALUM:    srcA = ALUResultM;
         default:     srcA = RD1E;
      endcase
      case (ForwardBE)
         FWD_RESULTW: writeDataE = ResultW;
         FWD_ALUM:    writeDataE = ALUResultM;
         default:     writeDataE = RD2E;
      endcase
   end

   assign srcB = ALUSrcE ? ExtImmE : writeDataE;

   alu #(.WIDTH(WIDTH)) uAlu (
      .a          (srcA),
      .b          (srcB),
      .op         (ALUControlE),
      .cin        (flagsR.c),
      .flagsIn    (flagsR),
      .result     (ALUResultE),
      .flags_next (aluFlags)
   );

   // Condition is judged on the flags as they stood before this instruction.
   always_comb begin
      case (CondE)
         COND_EQ: condEx = flagsR.z;
         COND_NE: condEx = ~flagsR.z;
         COND_CS: condEx = flagsR.c;
         COND_CC: condEx = ~flagsR.c;
         COND_MI: condEx = flagsR.n;
         COND_PL: condEx = ~flagsR.n;
         COND_VS: condEx = flagsR.v;
         COND_VC: condEx = ~flagsR.v;
         COND_HI: condEx = flagsR.c & ~flagsR.z;
         COND_LS: condEx = ~flagsR.c | flagsR.z;
         COND_GE: condEx = (flagsR.n == flagsR.v);
         COND_LT: condEx = (flagsR.n != flagsR.v);
         COND_GT: condEx = ~flagsR.z & (flagsR.n == flagsR.v);
         COND_LE: condEx = flagsR.z | (flagsR.n != flagsR.v);
         COND_AL: condEx = 1'b1;
         default: condEx = 1'b0;
      endcase
   end

   assign BranchTakenE = BranchE & condEx;
   assign FlagsQ       = flagsR;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         flagsR <= '0;
      end else begin
         if (condEx & FlagWriteE[1]) begin
            flagsR.n <= aluFlags.n;
            flagsR.z <= aluFlags.z;
         end
         if (condEx & FlagWriteE[0]) begin
            flagsR.c <= aluFlags.c;
            flagsR.v <= aluFlags.v;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ALUResultM <= '0;
         WriteDataM <= '0;
         WA3M       <= '0;
         RegWriteM  <= 1'b0;
         MemWriteM  <= 1'b0;
         MemToRegM  <= 1'b0;
         PCSrcM     <= 1'b0;
      end else begin
         ALUResultM <= ALUResultE;
         WriteDataM <= writeDataE;
         WA3M       <= WA3E;
         RegWriteM  <= RegWriteE & condEx;
         MemWriteM  <= MemWriteE & condEx;
         MemToRegM  <= MemToRegE;
         PCSrcM     <= PCSrcE & condEx;
      end
   end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against an arithmetic reference model
module tb_execute_stage;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [31:0] RD1E, RD2E, ExtImmE, ResultW;
   logic [3:0]  WA3E, ALUControlE, CondE;
   logic [1:0]  FlagWriteE, ForwardAE, ForwardBE;
   logic        ALUSrcE, RegWriteE, MemWriteE, MemToRegE, PCSrcE, BranchE;
   logic        BranchTakenE;
   logic [31:0] ALUResultE, ALUResultM, WriteDataM;
   logic [3:0]  WA3M, FlagsQ;
   logic        RegWriteM, MemWriteM, MemToRegM, PCSrcM;

   int nVec = 0;
   int nErr = 0;
   bit primed = 1'b0;

   logic [3:0]  mFlags;
   logic [31:0] mAluM, mWdM;
   logic [3:0]  mWa3M;
   logic        mRegW, mMemW, mMemToReg, mPcs;

   execute_stage #(.WIDTH(32)) dut (
      .Clk(Clk), .Rst(Rst), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .WA3E(WA3E),
      .ALUControlE(ALUControlE), .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUSrcE(ALUSrcE),
      .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemToRegE(MemToRegE), .PCSrcE(PCSrcE),
      .BranchE(BranchE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
      .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .ALUResultM(ALUResultM),
      .WriteDataM(WriteDataM), .WA3M(WA3M), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
      .MemToRegM(MemToRegM), .PCSrcM(PCSrcM), .FlagsQ(FlagsQ)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVec++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference ALU: exact integer arithmetic, carry/overflow read off the true result range.
   function automatic void refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fin, output logic [31:0] res, output logic [3:0] fout);
      longint ua, ub, sa, sb, s, cinL, notC;
      longint lim, smax, smin;
      bit arith, cOut;
      ua = longint'(a); ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      cinL = longint'(fin[1]); notC = 1 - cinL;
      lim = 64'sd4294967296; smax = 64'sd2147483647; smin = -64'sd2147483648;
      fout = fin; res = '0; arith = 1'b1; cOut = 1'b0; s = 0;
      case (op)
         4'd0: begin s = sa + sb; cOut = (ua + ub) >= lim; end
         4'd1: begin s = sa - sb; cOut = ua >= ub; end
         4'd5: begin s = sb - sa; cOut = ub >= ua; end
         4'd8: begin s = sa + sb + cinL; cOut = (ua + ub + cinL) >= lim; end
         4'd9: begin s = sa - sb - notC; cOut = ua >= (ub + notC); end
         4'd2: begin res = a & b; arith = 1'b0; end
         4'd3: begin res = a | b; arith = 1'b0; end
         4'd4: begin res = a ^ b; arith = 1'b0; end
         4'd6: begin res = b; arith = 1'b0; end
         4'd7: begin res = ~b; arith = 1'b0; end
         default: return;
      endcase
      if (arith) begin
         res = s[31:0];
         fout[1] = cOut;
         fout[0] = (s > smax) || (s < smin);
      end
      fout[3] = res[31];
      fout[2] = (res == 32'd0);
   endfunction

   function automatic bit refCond(input logic [3:0] cond, input logic [3:0] f);
      bit n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return c;
         4'd3:  return !c;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return c && !z;
         4'd9:  return !c || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic src, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [3:0] cond, input logic [1:0] fw,
                        input logic rw, input logic mw, input logic m2r, input logic pcs,
                        input logic br, input logic [3:0] wa3, input logic [31:0] resw,
                        input logic rst);
      ALUControlE = op; RD1E = a; RD2E = b; ExtImmE = imm; ALUSrcE = src;
      ForwardAE = fa; ForwardBE = fb; CondE = cond; FlagWriteE = fw;
      RegWriteE = rw; MemWriteE = mw; MemToRegE = m2r; PCSrcE = pcs; BranchE = br;
      WA3E = wa3; ResultW = resw; Rst = rst;
   endtask

   function automatic logic [31:0] fwdSel(input logic [1:0] sel, input logic [31:0] reg_v,
                                          input logic [31:0] resw, input logic [31:0] aluM);
      if (sel == 2'b01) return resw;
      if (sel == 2'b10) return aluM;
      return reg_v;
   endfunction

   task automatic tick();
      logic [31:0] a, wd, b, res;
      logic [3:0]  fnext;
      bit          cx;
      #2;
      a  = fwdSel(ForwardAE, RD1E, ResultW, mAluM);
      wd = fwdSel(ForwardBE, RD2E, ResultW, mAluM);
      b  = ALUSrcE ? ExtImmE : wd;
      refAlu(ALUControlE, a, b, mFlags, res, fnext);
      cx = refCond(CondE, mFlags);
      if (primed) begin
         check("alu_result_e", ALUResultE, res);
         check("branch_taken_e", {31'd0, BranchTakenE}, {31'd0, BranchE & cx});
      end
      if (Rst) begin
         mFlags = '0; mAluM = '0; mWdM = '0; mWa3M = '0;
         mRegW = 0; mMemW = 0; mMemToReg = 0; mPcs = 0;
      end else begin
         if (cx && FlagWriteE[1]) mFlags[3:2] = fnext[3:2];
         if (cx && FlagWriteE[0]) mFlags[1:0] = fnext[1:0];
         mAluM = res; mWdM = wd; mWa3M = WA3E;
         mRegW = RegWriteE & cx; mMemW = MemWriteE & cx;
         mMemToReg = MemToRegE; mPcs = PCSrcE & cx;
      end
      @(posedge Clk);
      #1;
      primed = 1'b1;
      check("alu_result_m", ALUResultM, mAluM);
      check("write_data_m", WriteDataM, mWdM);
      check("wa3_m", {28'd0, WA3M}, {28'd0, mWa3M});
      check("reg_write_m", {31'd0, RegWriteM}, {31'd0, mRegW});
      check("mem_write_m", {31'd0, MemWriteM}, {31'd0, mMemW});
      check("mem_to_reg_m", {31'd0, MemToRegM}, {31'd0, mMemToReg});
      check("pcsrc_m", {31'd0, PCSrcM}, {31'd0, mPcs});
      check("flags_q", {28'd0, FlagsQ}, {28'd0, mFlags});
   endtask

   initial begin
      // Reset with every input active
      drive(4'd0, 32'd1, 32'd2, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 1, 1, 1, 1, 1, 4'hA, 32'd0, 1);
      tick();
      check("reset_flags", {28'd0, FlagsQ}, 32'd0);
      check("reset_regwrite", {31'd0, RegWriteM}, 32'd0);

      // SUB 5-5 sets Z and C
      drive(4'd1, 32'd5, 32'd5, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 0, 0, 0, 0, 0, 4'h1, 32'd0, 0);
      tick();
      check("sub_result", ALUResultM, 32'd0);
      check("sub_flags", {28'd0, FlagsQ}, 32'h6);
      drive(4'd0, 32'd1, 32'd1, 32'd0, 0, 2'b00, 2'b00, 4'h0, 2'b00, 1, 0, 0, 0, 0, 4'h2, 32'd0, 0);
      tick();
      check("eq_regwrite", {31'd0, RegWriteM}, 32'd1);

      // Clear Z, then a failing EQ must be a bubble
      drive(4'd0, 32'd1, 32'd1, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 0, 0, 0, 0, 0, 4'h3, 32'd0, 0);
      tick();
      drive(4'd0, 32'd2, 32'd3, 32'd0, 0, 2'b00, 2'b00, 4'h0, 2'b11, 1, 1, 0, 1, 1, 4'h4, 32'd0, 0);
      #2;
      check("cond_fail_branch", {31'd0, BranchTakenE}, 32'd0);
      tick();
      check("cond_fail_memwrite", {31'd0, MemWriteM}, 32'd0);
      check("cond_fail_flags", {28'd0, FlagsQ}, 32'h0);

      // Signed overflow, then ADC carry behaviour
      drive(4'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 1, 0, 0, 0, 0, 4'h5, 32'd0, 0);
      tick();
      check("ovf_result", ALUResultM, 32'h80000000);
      check("ovf_flags", {28'd0, FlagsQ}, 32'h9);
      drive(4'd8, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 1, 0, 0, 0, 0, 4'h5, 32'd0, 0);
      tick();
      check("adc_no_carry", {31'd0, FlagsQ[1]}, 32'd0);
      drive(4'd1, 32'd5, 32'd5, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 0, 0, 0, 0, 0, 4'h6, 32'd0, 0);
      tick();
      drive(4'd8, 32'd1, 32'd1, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 1, 0, 0, 0, 0, 4'h6, 32'd0, 0);
      tick();
      check("adc_with_carry", ALUResultM, 32'd3);

      // Forwarding from ALUResultM and ResultW
      drive(4'd6, 32'd0, 32'd0, 32'h10, 1, 2'b00, 2'b00, 4'hE, 2'b00, 1, 0, 0, 0, 0, 4'h7, 32'd0, 0);
      tick();
      drive(4'd0, 32'hDEAD, 32'd0, 32'h4, 1, 2'b10, 2'b00, 4'hE, 2'b00, 1, 0, 0, 0, 0, 4'h8, 32'd0, 0);
      tick();
      check("fwd_alum", ALUResultM, 32'h14);
      drive(4'd6, 32'd0, 32'h55, 32'd0, 1, 2'b00, 2'b01, 4'hE, 2'b00, 0, 1, 0, 0, 0, 4'h9, 32'hAB, 0);
      tick();
      check("fwd_resultw", WriteDataM, 32'hAB);

      // Reset concurrent with a flag-writing compare
      drive(4'd1, 32'd9, 32'd3, 32'd0, 0, 2'b00, 2'b00, 4'hE, 2'b11, 1, 0, 0, 0, 0, 4'hB, 32'd0, 1);
      tick();
      check("midreset_flags", {28'd0, FlagsQ}, 32'd0);
      check("midreset_regwrite", {31'd0, RegWriteM}, 32'd0);

      // Randomized traffic; small operand pools make flag corners frequent
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         ra = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF + $urandom_range(0, 2) : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         drive(4'($urandom_range(0, 15)), ra, rb, $urandom, 1'($urandom),
               2'($urandom), 2'($urandom), 4'($urandom_range(0, 15)), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               4'($urandom), $urandom, ($urandom_range(0, 31) == 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
